fetch_decode_ctrl: RTL and testbench
====================================

Name: fetch_decode_ctrl

Overview:
Instruction fetch and main-control stage that sits directly upstream of the register/ALU/memory datapath. It holds the PC and a small instruction memory, and latches one instruction into an instruction register. It splits out the rs/rt/rd/immediate/FuncCode fields and drives the datapath control lines (RegDst, ALUSrc, ALUOp, MemRead, MemWrite, MemToReg, RegWrite). It resolves beq from the datapath's Zero flag. Each instruction takes two cycles: FETCH, then EXEC.

Parameters:
IMEM_DEPTH, 64, instruction memory depth in 32-bit words (power of 2); address width AW = log2(IMEM_DEPTH)
PC_RESET, 32'h0, byte address loaded into the PC on reset

Ports:
clock  in  1  single clock, rising edge
reset  in  1  synchronous, active-high
start  in  1  leaves IDLE on a 1-cycle pulse
imem_we  in  1  instruction memory write enable (loader)
imem_addr  in  AW  word address for a loader write
imem_wdata  in  32  loader write data
Zero  in  1  ALU zero flag from the datapath, sampled in EXEC
rs, rt, rd  out  5  IR[25:21], IR[20:16], IR[15:11]
immediate  out  16  IR[15:0]
FuncCode  out  6  IR[5:0]
RegDst, ALUSrc, MemRead, MemWrite, MemToReg, RegWrite  out  1 each  datapath controls
ALUOp  out  2  00 add, 01 sub, 10 use FuncCode
pc  out  32  byte address of the instruction held in IR
valid  out  1  high only in EXEC
halted  out  1  high in HALT
illegal  out  1  sticky; set when HALT is entered on an undefined opcode

Behaviour:
- Reset is synchronous and active-high. It applies on a rising edge of clock while reset=1.
  - state=IDLE, PC=PC_RESET, IR=0, illegal=0.
  - All control outputs 0, valid=0, halted=0.
  - Instruction memory contents are not cleared.
- Reset mid-operation discards any in-flight instruction. Write strobes drop in the same cycle.
- Instruction memory:
  - Synchronous write when imem_we=1; accepted in any state.
  - Read is combinational at imem[PC[AW+1:2]]. PC[1:0] is ignored.
- FSM:
  - IDLE -> FETCH when start=1.
  - FETCH: IR <= imem[PC]; all controls 0; next state EXEC.
  - EXEC: decode IR; controls are valid for exactly this one cycle. The datapath writes its register file and memory on the rising edge that ends EXEC. On that edge:
    - PC <= next PC (see below).
    - Next state is FETCH, or HALT for a halt or illegal opcode.
  - HALT: all controls 0, halted=1. Only reset leaves HALT. start is ignored.
- Next PC in EXEC:
  - Default: PC+4.
  - beq with Zero=1: PC + 4 + (sign-extended immediate << 2).
  - 32-bit arithmetic; overflow wraps.
  - Addresses beyond the memory alias modulo IMEM_DEPTH*4 through the index.
- Decode in EXEC, listing only signals that are 1 (all others 0):
  - R-type 000000: RegDst, RegWrite, ALUOp=10.
  - lw 100011: ALUSrc, MemRead, MemToReg, RegWrite, ALUOp=00.
  - sw 101011: ALUSrc, MemWrite, ALUOp=00.
  - beq 000100: ALUOp=01; write strobes 0.
  - addi 001000: ALUSrc, RegWrite, ALUOp=00.
  - halt 111111: none; go to HALT; PC is not advanced.
  - Any other opcode: none; go to HALT; illegal=1; PC is not advanced.
- Field outputs always reflect IR. Only the control outputs are gated by EXEC.
- A loader write to the address currently being fetched in FETCH takes effect at that clock edge. IR captures the old data (read-before-write).

Optional Feature:
JUMP_EN
- Defined: opcode 000010 (j) is legal.
  - Controls are all 0.
  - Next PC = {PC+4 [31:28], IR[25:0], 2'b00}.
- Undefined: 000010 is an illegal opcode and goes to HALT with illegal=1.

Test Plan:
1. Reset, then load a program and pulse start.
   - Program: imem[0]=add $5,$0,$0 (32'h00002820), imem[1]=32'hFC000000.
   - Required: EXEC at pc=0 shows RegDst=1, RegWrite=1, ALUOp=10, rd=5, valid=1 for one cycle.
   - Then halted=1, pc=4, illegal=0.
2. lw/sw decode.
   - Program: lw $10,20($0) (32'h8C0A0014), then sw (32'hAC0A0018).
   - Required: first EXEC gives ALUSrc=1, MemRead=1, MemToReg=1, RegWrite=1, immediate=16'h0014.
   - Second EXEC gives MemWrite=1, RegWrite=0, immediate=16'h0018.
3. beq at pc=8 with immediate 16'hFFFE.
   - Zero=1 -> next pc=8+4-8=4.
   - Repeat with Zero=0 -> next pc=12.
4. Opcode 6'h3E at pc=0.
   - Required: halted=1, illegal=1, pc stays 0.
   - start pulses are ignored; reset returns to IDLE with illegal=0.
5. Assert reset during EXEC of an addi.
   - Required: RegWrite=0 on the next cycle; state IDLE; pc=PC_RESET.
6. JUMP_EN defined: j 0x10 (32'h08000010) at pc=0 -> next pc=0x40.
   - JUMP_EN undefined: same instruction -> illegal=1.

Source files
------------

// File: rtl/fetch_decode_ctrl.sv
// fetch_decode_ctrl: two-cycle (FETCH/EXEC) instruction fetch and main
// control stage. Holds the PC, a loader-writable instruction memory and the
// instruction register, splits the instruction fields and drives the
// datapath control lines; beq is resolved from the datapath Zero flag.
//
// Ports:
//   clock, reset              rising-edge clock, synchronous active-high reset
//   start                     pulse to leave IDLE
//   imem_we/addr/wdata        instruction memory loader write port
//   Zero                      ALU zero flag, sampled in EXEC (beq)
//   rs, rt, rd, immediate,
//   FuncCode                  fields of the instruction register
//   RegDst, ALUSrc, MemRead,
//   MemWrite, MemToReg,
//   RegWrite, ALUOp           datapath controls, non-zero only in EXEC
//   pc                        byte address of the instruction in IR
//   valid, halted, illegal    EXEC marker, HALT marker, sticky illegal flag
//
// Build option: define JUMP_EN to make opcode 000010 (j) legal.
module fetch_decode_ctrl #(
  parameter int unsigned IMEM_DEPTH = 64,
  parameter logic [31:0] PC_RESET   = 32'h0
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          imem_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] imem_addr,
  input  logic [31:0]                   imem_wdata,
  input  logic                          Zero,
  output logic [4:0]                    rs,
  output logic [4:0]                    rt,
  output logic [4:0]                    rd,
  output logic [15:0]                   immediate,
  output logic [5:0]                    FuncCode,
  output logic                          RegDst,
  output logic                          ALUSrc,
  output logic                          MemRead,
  output logic                          MemWrite,
  output logic                          MemToReg,
  output logic                          RegWrite,
  output logic [1:0]                    ALUOp,
  output logic [31:0]                   pc,
  output logic                          valid,
  output logic                          halted,
  output logic                          illegal
);

  localparam int unsigned AW = $clog2(IMEM_DEPTH);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_HALT = 6'b111111;
`ifdef JUMP_EN
  localparam logic [5:0] OP_J    = 6'b000010;
`endif

  // control vector: {RegDst, ALUSrc, MemRead, MemWrite, MemToReg, RegWrite, ALUOp[1:0]}
  localparam int unsigned CW = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t          r_state;
  logic [31:0]     r_pc;
  logic [31:0]     r_ir;
  logic [CW-1:0]   r_ctrl;
  logic            r_valid;
  logic            r_halted;
  logic            r_illegal;
  logic [31:0]     r_imem [IMEM_DEPTH];

  logic [31:0]     w_fetch_word;
  logic [CW-1:0]   w_fetch_ctrl;
  logic [5:0]      w_ir_op;
  logic            w_ir_legal;
  logic [31:0]     w_pc_plus4;
  logic [31:0]     w_br_target;
  logic [31:0]     w_next_pc;

  // Loader port; memory contents survive reset.
  always_ff @(posedge clock) begin
    if (imem_we) r_imem[imem_addr] <= imem_wdata;
  end

  // PC[1:0] and bits above the index are dropped, so addresses alias.
  assign w_fetch_word = r_imem[r_pc[AW+1:2]];
  assign w_ir_op      = r_ir[31:26];
  assign w_pc_plus4   = r_pc + 32'd4;
  assign w_br_target  = w_pc_plus4 + {{14{r_ir[15]}}, r_ir[15:0], 2'b00};

  // Controls are decoded from the word being fetched so they are registered
  // into place exactly when IR is, and are present throughout EXEC.
  always_comb begin
    w_fetch_ctrl = '0;
    case (w_fetch_word[31:26])
      OP_R:    w_fetch_ctrl = 8'b1000_0110;
      OP_LW:   w_fetch_ctrl = 8'b0110_1100;
      OP_SW:   w_fetch_ctrl = 8'b0101_0000;
      OP_BEQ:  w_fetch_ctrl = 8'b0000_0001;
      OP_ADDI: w_fetch_ctrl = 8'b0100_0100;
      default: w_fetch_ctrl = '0;
    endcase
  end

  // Opcodes that execute and advance the PC (halt is handled separately).
  always_comb begin
    w_ir_legal = 1'b0;
    case (w_ir_op)
      OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI: w_ir_legal = 1'b1;
`ifdef JUMP_EN
      OP_J:                                w_ir_legal = 1'b1;
`endif
      default:                             w_ir_legal = 1'b0;
    endcase
  end

  // Next PC selection in EXEC.
  always_comb begin
    w_next_pc = w_pc_plus4;
    if (w_ir_op == OP_BEQ && Zero) w_next_pc = w_br_target;
`ifdef JUMP_EN
    if (w_ir_op == OP_J) w_next_pc = {w_pc_plus4[31:28], r_ir[25:0], 2'b00};
`endif
  end

  // Sequencer with registered controls and status.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_pc      <= PC_RESET;
      r_ir      <= '0;
      r_ctrl    <= '0;
      r_valid   <= 1'b0;
      r_halted  <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_ctrl  <= '0;
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) r_state <= S_FETCH;
        end
        S_FETCH: begin
          r_ir    <= w_fetch_word;
          r_ctrl  <= w_fetch_ctrl;
          r_valid <= 1'b1;
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          if (w_ir_op == OP_HALT) begin
            r_halted <= 1'b1;
            r_state  <= S_HALT;
          end else if (!w_ir_legal) begin
            r_halted  <= 1'b1;
            r_illegal <= 1'b1;
            r_state   <= S_HALT;
          end else begin
            r_pc    <= w_next_pc;
            r_state <= S_FETCH;
          end
        end
        S_HALT: begin
          r_halted <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rs        = r_ir[25:21];
  assign rt        = r_ir[20:16];
  assign rd        = r_ir[15:11];
  assign immediate = r_ir[15:0];
  assign FuncCode  = r_ir[5:0];

  assign RegDst    = r_ctrl[7];
  assign ALUSrc    = r_ctrl[6];
  assign MemRead   = r_ctrl[5];
  assign MemWrite  = r_ctrl[4];
  assign MemToReg  = r_ctrl[3];
  assign RegWrite  = r_ctrl[2];
  assign ALUOp     = r_ctrl[1:0];

  assign pc        = r_pc;
  assign valid     = r_valid;
  assign halted    = r_halted;
  assign illegal   = r_illegal;

endmodule

// File: tb/tb_fetch_decode_ctrl.sv
// Bench for fetch_decode_ctrl: table of single-instruction programs plus
// hand-written multi-cycle sequences; expected EXEC cycles are queued when
// a program is started and popped by a negedge monitor whenever valid=1.
module tb_fetch_decode_ctrl;

  localparam logic [31:0] HALT_W = 32'hFC000000;

  logic        clock, reset, start, imem_we, Zero;
  logic [5:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [4:0]  rs, rt, rd;
  logic [15:0] immediate;
  logic [5:0]  FuncCode;
  logic        RegDst, ALUSrc, MemRead, MemWrite, MemToReg, RegWrite;
  logic [1:0]  ALUOp;
  logic [31:0] pc;
  logic        valid, halted, illegal;

  fetch_decode_ctrl dut (
    .clock(clock), .reset(reset), .start(start),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .Zero(Zero),
    .rs(rs), .rt(rt), .rd(rd), .immediate(immediate), .FuncCode(FuncCode),
    .RegDst(RegDst), .ALUSrc(ALUSrc), .MemRead(MemRead), .MemWrite(MemWrite),
    .MemToReg(MemToReg), .RegWrite(RegWrite), .ALUOp(ALUOp),
    .pc(pc), .valid(valid), .halted(halted), .illegal(illegal)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] pc;
    logic [7:0]  ctrl;
    logic [31:0] ir;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    logic        zero;
    logic [7:0]  ctrl;
  } vec_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  logic mon_en = 1'b0;

  wire [7:0] ctrl_w = {RegDst, ALUSrc, MemRead, MemWrite, MemToReg, RegWrite, ALUOp};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: each EXEC cycle must match the next queued record.
  always @(negedge clock) begin
    if (mon_en) begin
      if (valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_exec: got valid at pc=%h expected no EXEC", pc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("exec_pc", pc, e.pc);
          check("exec_ctrl", 32'(ctrl_w), 32'(e.ctrl));
          check("exec_fields", 32'({rs, rt, rd, FuncCode}), 32'({e.ir[25:11], e.ir[5:0]}));
          check("exec_imm", 32'(immediate), 32'(e.ir[15:0]));
        end
      end else begin
        check("idle_ctrl", 32'(ctrl_w), 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic load(input int addr, input logic [31:0] data);
    imem_we    = 1'b1;
    imem_addr  = 6'(addr);
    imem_wdata = data;
    tick();
    imem_we    = 1'b0;
  endtask

  task automatic push(input logic [31:0] p, input logic [7:0] c, input logic [31:0] ir);
    exp_t e;
    e.pc = p; e.ctrl = c; e.ir = ir;
    sb.push_back(e);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_halt(input int max);
    int n;
    n = 0;
    while (!halted && n < max) begin
      tick();
      n++;
    end
    check("halt_reached", 32'(halted), 32'd1);
  endtask

  vec_t vecs[6];

  initial begin
    reset = 1'b0; start = 1'b0; imem_we = 1'b0; imem_addr = '0;
    imem_wdata = '0; Zero = 1'b0;

    vecs[0] = '{32'h00002820, 1'b0, 8'h86};  // add $5,$0,$0
    vecs[1] = '{32'h012A4022, 1'b0, 8'h86};  // sub $8,$9,$10
    vecs[2] = '{32'h8C0A0014, 1'b0, 8'h6C};  // lw
    vecs[3] = '{32'hAC0A0018, 1'b0, 8'h50};  // sw
    vecs[4] = '{32'h1000FFFE, 1'b0, 8'h01};  // beq not taken
    vecs[5] = '{32'h20010005, 1'b0, 8'h44};  // addi

    // Reset state
    do_reset();
    check("rst_pc", pc, 32'h0);
    check("rst_status", 32'({valid, halted, illegal}), 32'd0);
    check("rst_ctrl", 32'(ctrl_w), 32'd0);
    check("rst_ir", 32'({rs, rt, immediate}), 32'd0);
    mon_en = 1'b1;

    // Table: one instruction followed by halt
    for (int i = 0; i < 6; i++) begin
      do_reset();
      load(0, vecs[i].instr);
      load(1, HALT_W);
      Zero = vecs[i].zero;
      push(32'd0, vecs[i].ctrl, vecs[i].instr);
      push(32'd4, 8'h00, HALT_W);
      pulse_start();
      wait_halt(20);
      check("vec_halt_pc", pc, 32'd4);
      check("vec_illegal", 32'(illegal), 32'd0);
      check("vec_sb_empty", 32'(sb.size()), 32'd0);
    end

    // lw then sw back to back
    do_reset();
    load(0, 32'h8C0A0014);
    load(1, 32'hAC0A0018);
    load(2, HALT_W);
    push(32'd0, 8'h6C, 32'h8C0A0014);
    push(32'd4, 8'h50, 32'hAC0A0018);
    push(32'd8, 8'h00, HALT_W);
    pulse_start();
    wait_halt(20);
    check("lwsw_pc", pc, 32'd8);
    check("lwsw_sb_empty", 32'(sb.size()), 32'd0);

    // beq at pc=8, taken once (-> 4) then not taken (-> 12)
    do_reset();
    load(0, 32'h20000000);
    load(1, 32'h20000000);
    load(2, 32'h1000FFFE);
    load(3, HALT_W);
    Zero = 1'b1;
    push(32'd0, 8'h44, 32'h20000000);
    push(32'd4, 8'h44, 32'h20000000);
    push(32'd8, 8'h01, 32'h1000FFFE);
    push(32'd4, 8'h44, 32'h20000000);
    push(32'd8, 8'h01, 32'h1000FFFE);
    push(32'd12, 8'h00, HALT_W);
    pulse_start();
    for (int n = 0; n < 20; n++) begin
      tick();
      if (valid && pc == 32'd8) break;
    end
    check("beq_reached", 32'({valid, pc}), 32'({1'b1, 32'd8}));
    tick();
    check("beq_taken_pc", pc, 32'd4);
    Zero = 1'b0;
    wait_halt(30);
    check("beq_fall_pc", pc, 32'd12);
    check("beq_sb_empty", 32'(sb.size()), 32'd0);

    // Undefined opcode 6'h3E at pc=0
    do_reset();
    load(0, 32'hF8000000);
    push(32'd0, 8'h00, 32'hF8000000);
    pulse_start();
    wait_halt(20);
    check("ill_flag", 32'(illegal), 32'd1);
    check("ill_pc", pc, 32'd0);
    pulse_start();
    repeat (4) tick();
    check("ill_stuck", 32'({halted, illegal}), 32'd3);
    check("ill_stuck_pc", pc, 32'd0);
    do_reset();
    check("ill_cleared", 32'({halted, illegal, valid}), 32'd0);
    repeat (4) tick();
    check("ill_idle_pc", pc, 32'd0);

    // Reset during EXEC of addi
    do_reset();
    load(0, 32'h20010005);
    push(32'd0, 8'h44, 32'h20010005);
    pulse_start();
    for (int n = 0; n < 10; n++) begin
      if (valid) break;
      tick();
    end
    check("rexec_regwrite_before", 32'(RegWrite), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rexec_after", 32'({RegWrite, valid}), 32'd0);
    check("rexec_pc", pc, 32'd0);
    repeat (3) tick();
    check("rexec_idle", 32'({valid, halted}), 32'd0);
    check("rexec_sb_empty", 32'(sb.size()), 32'd0);

    // j 0x10 at pc=0
    do_reset();
    load(0, 32'h08000010);
    load(16, HALT_W);
    push(32'd0, 8'h00, 32'h08000010);
`ifdef JUMP_EN
    push(32'h40, 8'h00, HALT_W);
    pulse_start();
    wait_halt(20);
    check("j_pc", pc, 32'h40);
    check("j_illegal", 32'(illegal), 32'd0);
`else
    pulse_start();
    wait_halt(20);
    check("j_pc", pc, 32'h0);
    check("j_illegal", 32'(illegal), 32'd1);
`endif
    check("j_sb_empty", 32'(sb.size()), 32'd0);

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
